// File: rtl/counter_min_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_min_if                                         |
// | Description : Control/preset/status bundle for the minutes stage.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface counter_min_if;
   logic       EN;
   logic       PE;
   logic       ADJ;
   logic [7:0] pre_min;
   logic [7:0] show_min;
   logic       cin_min;
   logic       pre_err;

   // Controller side: drives the controls and preset value, observes the count
   modport master (
      output EN, PE, ADJ, pre_min,
      input  show_min, cin_min, pre_err
   );

   // Counter side
   modport slave (
      input  EN, PE, ADJ, pre_min,
      output show_min, cin_min, pre_err
   );
endinterface
`default_nettype wire

// File: rtl/counter_min.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_min                                            |
// | Description : BCD minutes counter clocked by the seconds carry, with |
// |               validated preset, manual adjust and a one-cycle carry  |
// |               pulse to the hour stage.                               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module counter_min #(
   parameter logic [7:0] MAX_CNT = 8'h59
) (
   input  wire logic       cin_sec,
   input  wire logic       CR,
   counter_min_if.slave    bus
);

   // COUNT: below terminal count; TERM: show_min sits at MAX_CNT
   localparam logic [0:0] c_ST_COUNT = 1'b0;
   localparam logic [0:0] c_ST_TERM  = 1'b1;

   logic [0:0] state_q,    state_d;
   logic [7:0] show_min_q, show_min_d;
   logic       cin_min_q,  cin_min_d;
   logic       pre_err_q,  pre_err_d;

   logic [7:0] w_inc;
   logic       w_pre_valid;

   // State register: all flops cleared asynchronously by CR
   always_ff @(posedge cin_sec or posedge CR) begin
      if (CR) begin
         state_q    <= c_ST_COUNT;
         show_min_q <= 8'h00;
         cin_min_q  <= 1'b0;
         pre_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         show_min_q <= show_min_d;
         cin_min_q  <= cin_min_d;
         pre_err_q  <= pre_err_d;
      end
   end

   // Next-state: BCD step, preset check and action priority PE > ADJ > EN > hold
   always_comb begin
      // One BCD step; TERM wraps to zero so the count never exceeds MAX_CNT
      w_inc = 8'h00;
      if (state_q != c_ST_TERM) begin
         if (show_min_q[3:0] == 4'd9) begin
            w_inc = {show_min_q[7:4] + 4'd1, 4'd0};
         end else begin
            w_inc = {show_min_q[7:4], show_min_q[3:0] + 4'd1};
         end
      end

      w_pre_valid = (bus.pre_min[7:4] <= 4'd9) && (bus.pre_min[3:0] <= 4'd9) &&
                    (bus.pre_min <= MAX_CNT);

      show_min_d = show_min_q;
      cin_min_d  = 1'b0;
      pre_err_d  = pre_err_q;

      if (bus.PE) begin
         if (w_pre_valid) begin
            show_min_d = bus.pre_min;
            pre_err_d  = 1'b0;
         end else begin
            pre_err_d  = 1'b1;
         end
      end else if (bus.ADJ) begin
         // Manual adjust wraps silently; the hour stage must not advance
         show_min_d = w_inc;
      end else if (bus.EN) begin
         show_min_d = w_inc;
         cin_min_d  = (state_q == c_ST_TERM);
      end

      state_d = (show_min_d == MAX_CNT) ? c_ST_TERM : c_ST_COUNT;
   end

   // Outputs come straight from flops: no input-to-output combinational path
   always_comb begin
      bus.show_min = show_min_q;
      bus.cin_min  = cin_min_q;
      bus.pre_err  = pre_err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_min.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_counter_min                                         |
// | Description : Table-driven self-checking bench for counter_min.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_counter_min;

   typedef struct {
      logic       pe;
      logic       adj;
      logic       en;
      logic [7:0] pre;
      logic [7:0] show;
      logic       cin;
      logic       err;
   } vec_t;

   logic clk = 1'b0;
   logic cr  = 1'b1;

   counter_min_if ifc ();

   counter_min #(.MAX_CNT(8'h59)) u_dut (
      .cin_sec (clk),
      .CR      (cr),
      .bus     (ifc.slave)
   );

   always #5 clk = ~clk;

   int n_vec    = 0;
   int n_err    = 0;
   int rises    = 0;
   int exp_roll = 0;

   // Count every rising edge of the carry, including any glitch from reset
   always @(posedge ifc.cin_min) rises = rises + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      n_vec = n_vec + 1;
      if (got !== want) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] show, input logic cin, input logic err);
      chk({nm, ".show_min"}, ifc.show_min, show);
      chk({nm, ".cin_min"}, {7'd0, ifc.cin_min}, {7'd0, cin});
      chk({nm, ".pre_err"}, {7'd0, ifc.pre_err}, {7'd0, err});
   endtask

   // One clock edge, then the BCD-legality/range check every edge must satisfy
   task automatic tick();
      logic ok;
      @(posedge clk);
      #1;
      ok = (ifc.show_min[7:4] <= 4'd9) && (ifc.show_min[3:0] <= 4'd9) &&
           (ifc.show_min <= 8'h59);
      chk("legal_bcd_range", {7'd0, ok}, 8'h01);
   endtask

   task automatic drive(input logic pe, input logic adj, input logic en, input logic [7:0] pre);
      ifc.PE      = pe;
      ifc.ADJ     = adj;
      ifc.EN      = en;
      ifc.pre_min = pre;
   endtask

   function automatic vec_t mk(input logic pe, input logic adj, input logic en,
                               input logic [7:0] pre, input logic [7:0] show,
                               input logic cin, input logic err);
      vec_t v;
      v.pe = pe; v.adj = adj; v.en = en; v.pre = pre;
      v.show = show; v.cin = cin; v.err = err;
      return v;
   endfunction

   vec_t vt[$];

   initial begin
      //        pe adj en  pre    show   cin err
      vt.push_back(mk(1, 0, 0, 8'h55, 8'h55, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h56, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h57, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h58, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h59, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h00, 1, 0));  // rollover
      vt.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h6A, 8'h00, 0, 1));  // bad units nibble
      vt.push_back(mk(1, 0, 0, 8'h61, 8'h00, 0, 1));  // above MAX_CNT
      vt.push_back(mk(1, 0, 0, 8'h12, 8'h12, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h59, 8'h59, 0, 0));
      vt.push_back(mk(0, 1, 1, 8'h00, 8'h00, 0, 0));  // ADJ wrap, no carry
      vt.push_back(mk(1, 0, 0, 8'h09, 8'h09, 0, 0));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h10, 0, 0));  // units carry
      vt.push_back(mk(1, 0, 0, 8'h59, 8'h59, 0, 0));
      vt.push_back(mk(1, 0, 1, 8'h30, 8'h30, 0, 0));  // PE beats EN at TERM
      vt.push_back(mk(0, 0, 0, 8'h00, 8'h30, 0, 0));
      vt.push_back(mk(0, 0, 0, 8'h00, 8'h30, 0, 0));
      vt.push_back(mk(0, 0, 0, 8'h00, 8'h30, 0, 0));
      vt.push_back(mk(0, 1, 0, 8'h00, 8'h31, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h5A, 8'h31, 0, 1));
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h32, 0, 1));  // error is sticky
      vt.push_back(mk(1, 0, 0, 8'h60, 8'h32, 0, 1));
      vt.push_back(mk(1, 1, 0, 8'h19, 8'h19, 0, 0));  // PE beats ADJ
      vt.push_back(mk(0, 0, 1, 8'h00, 8'h20, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h99, 8'h20, 0, 1));
      vt.push_back(mk(1, 0, 0, 8'h59, 8'h59, 0, 0));
      vt.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0));

      // Reset state before any clock edge, then held across edges
      drive(0, 0, 1, 8'h00);
      #2;
      chk_all("reset_async", 8'h00, 1'b0, 1'b0);
      tick();
      chk_all("reset_hold0", 8'h00, 1'b0, 1'b0);
      tick();
      cr = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].pe, vt[i].adj, vt[i].en, vt[i].pre);
         if (vt[i].cin) exp_roll = exp_roll + 1;
         tick();
         chk_all($sformatf("vec%0d", i), vt[i].show, vt[i].cin, vt[i].err);
      end

      // Mid-cycle CR at 37 with pre_err set
      drive(1, 0, 0, 8'h37); tick();
      drive(1, 0, 0, 8'h7A); tick();
      chk_all("pre37_bad", 8'h37, 1'b0, 1'b1);
      drive(0, 0, 1, 8'h00);
      #2; cr = 1'b1; #1;
      chk_all("cr_mid_cycle", 8'h00, 1'b0, 1'b0);
      tick();
      chk_all("cr_held1", 8'h00, 1'b0, 1'b0);
      tick();
      chk_all("cr_held2", 8'h00, 1'b0, 1'b0);

      // Preset lands on the first edge after CR release
      cr = 1'b0;
      drive(1, 0, 0, 8'h59); tick();
      chk_all("post_cr_load", 8'h59, 1'b0, 1'b0);

      // Carry pulse aborted by CR must not create an extra rising edge
      drive(0, 0, 1, 8'h00); tick();
      exp_roll = exp_roll + 1;
      chk_all("roll_before_abort", 8'h00, 1'b1, 1'b0);
      #2; cr = 1'b1; #1;
      chk_all("carry_abort", 8'h00, 1'b0, 1'b0);
      tick();
      cr = 1'b0;
      tick();
      chk_all("count_after_abort", 8'h01, 1'b0, 1'b0);
      tick();
      chk_all("count_after_abort2", 8'h02, 1'b0, 1'b0);

      chk("carry_rise_count", 8'(rises), 8'(exp_roll));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
